// File: rtl/ropuf_pkg.sv
// Shared definitions for the ROPUF measurement path: FSM states of the
// pair comparator and default sizing constants.
package ropuf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int DEF_CNT_W  = 16;
   localparam int DEF_WINDOW = 1024;
   localparam int DEF_SETTLE = 16;

   // Larger of two sizing parameters; used to size the shared phase timer.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: 2-flop synchroniser, registered rising-edge
// detector and a saturating edge counter with clear and count-enable.
// Both channels of a pair use this block so their latency is identical.
module ro_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   (* DONT_TOUCH = "TRUE" *)
   input  logic                        ro_i,
   input  logic                        clr_i,
   input  logic                        en_i,
   output logic [CNT_W-1:0]            cnt_o
);

   (* ASYNC_REG = "TRUE" *) logic sync1_q;
   (* ASYNC_REG = "TRUE" *) logic sync2_q;
   logic             prev_q;
   logic             rise;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Bring the free-running oscillator into the clock domain and keep the
   // previous synchronised level for edge detection.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= ro_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;

   // Clear wins over counting; the counter sticks at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && rise && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_pair_comparator.sv
// Measures one RO pair: lets both oscillators settle, counts their rising
// edges over a fixed window and reports which one ran faster.
// Optional feature macro: ROPUF_MARGIN_EN adds the |A-B| < MARGIN
// "Unstable" flag; without it no subtractor is built and Unstable is 0.
module ro_pair_comparator
   import ropuf_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int WINDOW_CYCLES = DEF_WINDOW,
   parameter int SETTLE_CYCLES = DEF_SETTLE,
   parameter int MARGIN        = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             RO_A,
   input  logic             RO_B,
   output logic             RO_Enable,
   output logic             RO_Reset,
   output logic             Busy,
   output logic             Done,
   output logic             Response,
   output logic             Tie,
   output logic             Unstable,
   output logic [CNT_W-1:0] Count_A,
   output logic [CNT_W-1:0] Count_B
);

   localparam int TMR_W = $clog2(max2(WINDOW_CYCLES, SETTLE_CYCLES));
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             clr, capture, cnt_en;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic [CNT_W-1:0] count_a_q, count_b_q;
   logic             resp_q, tie_q, unstable_q, unstable_d;

   // Identical channels so both see the same synchroniser/detector skew.
   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .ro_i   (RO_A),
      .clr_i  (clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .ro_i   (RO_B),
      .clr_i  (clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt_b)
   );

   // State and phase-timer registers.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next-state, timer and oscillator control; outputs decode the state only.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      clr       = 1'b0;
      capture   = 1'b0;
      cnt_en    = 1'b0;
      RO_Enable = 1'b0;
      RO_Reset  = 1'b1;
      Busy      = 1'b1;
      Done      = 1'b0;
      case (state_q)
         IDLE: begin
            Busy = 1'b0;
            if (Start) begin
               state_d = SETTLE;
               tmr_d   = '0;
               clr     = 1'b1;
            end
         end
         SETTLE: begin
            RO_Enable = 1'b1;
            RO_Reset  = 1'b0;
            if (tmr_q == SETTLE_LAST) begin
               state_d = COUNT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         COUNT: begin
            RO_Enable = 1'b1;
            RO_Reset  = 1'b0;
            cnt_en    = 1'b1;
            if (tmr_q == WINDOW_LAST) begin
               state_d = DONE;
               capture = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ROPUF_MARGIN_EN
   logic [CNT_W:0] diff;

   // Absolute difference one bit wider than the counts so it never overflows.
   always_comb begin
      diff = (cnt_a >= cnt_b) ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                              : ({1'b0, cnt_b} - {1'b0, cnt_a});
      unstable_d = (diff < (CNT_W+1)'(MARGIN));
   end
`else
   logic unused_margin;
   assign unused_margin = ^MARGIN;
   assign unstable_d    = 1'b0;
`endif

   // Results are captured on the COUNT->DONE edge so they are valid with Done
   // and then held until the next measurement overwrites them.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         count_a_q  <= '0;
         count_b_q  <= '0;
         resp_q     <= 1'b0;
         tie_q      <= 1'b0;
         unstable_q <= 1'b0;
      end else if (capture) begin
         count_a_q  <= cnt_a;
         count_b_q  <= cnt_b;
         resp_q     <= (cnt_a > cnt_b);
         tie_q      <= (cnt_a == cnt_b);
         unstable_q <= unstable_d;
      end
   end

   assign Count_A  = count_a_q;
   assign Count_B  = count_b_q;
   assign Response = resp_q;
   assign Tie      = tie_q;
   assign Unstable = unstable_q;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Randomised bench for ro_pair_comparator: a wide (16-bit) and a narrow
// (4-bit, saturating) instance share stimulus; expected counts come from the
// sampled oscillator history.
module tb_ro_pair_comparator;

   localparam int S    = 4;
   localparam int W    = 100;
   localparam int MRG  = 8;
   localparam int HMAX = 32768;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic Start = 1'b0;
   logic RO_A = 1'b1, RO_B = 1'b1;

   logic RO_Enable, RO_Reset, Busy, Done, Response, Tie, Unstable;
   logic [15:0] Count_A, Count_B;
   logic n_en, n_rst, n_busy, n_done, n_resp, n_tie, n_unst;
   logic [3:0] n_ca, n_cb;

   ro_pair_comparator #(.CNT_W(16), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .MARGIN(MRG)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .RO_A(RO_A), .RO_B(RO_B),
      .RO_Enable(RO_Enable), .RO_Reset(RO_Reset), .Busy(Busy), .Done(Done),
      .Response(Response), .Tie(Tie), .Unstable(Unstable),
      .Count_A(Count_A), .Count_B(Count_B));

   ro_pair_comparator #(.CNT_W(4), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .MARGIN(MRG)) dut_n (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .RO_A(RO_A), .RO_B(RO_B),
      .RO_Enable(n_en), .RO_Reset(n_rst), .Busy(n_busy), .Done(n_done),
      .Response(n_resp), .Tie(n_tie), .Unstable(n_unst),
      .Count_A(n_ca), .Count_B(n_cb));

   always #5 Clk = ~Clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, ndone = 0;
   bit ha [HMAX], hb [HMAX];
   int per_a = 8, per_b = 10, off_a = 0, off_b = 0, pa = 0, pb = 0;
   int e0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Edge count and sampled oscillator history; ha[n] is RO_A at edge n.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (cyc + 1 < HMAX) begin
         ha[cyc+1] <= RO_A;
         hb[cyc+1] <= RO_B;
      end
      if (Done) ndone <= ndone + 1;
   end

   // Oscillator models: held at 1 while in reset, otherwise a square wave.
   always @(posedge Clk) begin
      #1;
      if (RO_Reset) begin
         pa = off_a; pb = off_b; RO_A = 1'b1; RO_B = 1'b1;
      end else begin
         pa = (pa + 1) % per_a;
         pb = (pb + 1) % per_b;
         RO_A = (pa < per_a / 2) ? 1'b0 : 1'b1;
         RO_B = (pb < per_b / 2) ? 1'b0 : 1'b1;
      end
   end

   // Reference count: a rise first sampled at edge k reaches the counter at
   // edge k+2; the result holds rises landing on edges e0+S+1 .. e0+S+W-1.
   function automatic int exp_cnt(input int s0, input bit ch, input int maxv);
      int c = 0;
      for (int k = s0 + S - 1; k <= s0 + S + W - 3; k++)
         if (ch ? (hb[k] && !hb[k-1]) : (ha[k] && !ha[k-1])) c++;
      return (c > maxv) ? maxv : c;
   endfunction

   function automatic bit exp_unst(input int a, input int b);
`ifdef ROPUF_MARGIN_EN
      return ((a > b) ? a - b : b - a) < MRG;
`else
      return (a != b) && 1'b0;
`endif
   endfunction

   task automatic start_meas(input int p_a, input int p_b, input int o_a, input int o_b);
      @(negedge Clk);
      per_a = p_a; per_b = p_b; off_a = o_a; off_b = o_b;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      e0 = cyc;
      Start = 1'b0;
   endtask

   task automatic finish_meas(input bit repulse);
      bit got = 1'b0;
      int nd0 = ndone;
      int ea, eb, na, nb;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         Start = repulse && ((cyc == e0 + 2) || (cyc == e0 + 50));
         if (Done) begin got = 1'b1; break; end
      end
      Start = 1'b0;
      chk("done_seen", got, 1);
      chk("done_cycle", cyc - e0, S + W);
      ea = exp_cnt(e0, 1'b0, 65535); eb = exp_cnt(e0, 1'b1, 65535);
      na = exp_cnt(e0, 1'b0, 15);    nb = exp_cnt(e0, 1'b1, 15);
      chk("count_a", Count_A, ea);
      chk("count_b", Count_B, eb);
      chk("response", Response, ea > eb);
      chk("tie", Tie, ea == eb);
      chk("unstable", Unstable, exp_unst(ea, eb));
      chk("busy_done", Busy, 1);
      chk("ro_reset_done", RO_Reset, 1);
      chk("n_count_a", n_ca, na);
      chk("n_count_b", n_cb, nb);
      chk("n_response", n_resp, na > nb);
      chk("n_tie", n_tie, na == nb);
      chk("n_done", n_done, 1);
      @(negedge Clk);
      chk("done_pulse", Done, 0);
      chk("busy_after", Busy, 0);
      chk("done_count", ndone - nd0, 1);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      chk("rst_ro_en", RO_Enable, 0);
      chk("rst_ro_rst", RO_Reset, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_resp", Response, 0);
      chk("rst_tie", Tie, 0);
      chk("rst_unst", Unstable, 0);
      chk("rst_cnt_a", Count_A, 0);
      chk("rst_cnt_b", Count_B, 0);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      // Directed cases from the measurement plan.
      start_meas(8, 10, 0, 0);
      finish_meas(1'b0);
      chk("plan_a_range", (Count_A >= 12) && (Count_A <= 13), 1);
      chk("plan_b_range", (Count_B >= 9) && (Count_B <= 10), 1);
      start_meas(10, 10, 0, 0);
      finish_meas(1'b0);
      chk("inphase_tie", Tie, 1);
      start_meas(4, 40, 0, 0);
      finish_meas(1'b0);
      chk("sat_count", n_ca, 15);
      start_meas(8, 10, 3, 1);
      finish_meas(1'b1);

      // Reset in the middle of COUNT discards the measurement.
      begin
         int nd0;
         start_meas(6, 9, 0, 0);
         nd0 = ndone;
         while (cyc < e0 + 50) @(negedge Clk);
         Reset_n = 1'b0;
         @(negedge Clk);
         Reset_n = 1'b1;
         chk("mrst_busy", Busy, 0);
         chk("mrst_ro_rst", RO_Reset, 1);
         chk("mrst_ro_en", RO_Enable, 0);
         chk("mrst_done", Done, 0);
         chk("mrst_cnt_a", Count_A, 0);
         repeat (120) @(negedge Clk);
         chk("mrst_no_done", ndone - nd0, 0);
      end
      start_meas(7, 11, 2, 5);
      finish_meas(1'b0);

      // Random periods and phases.
      for (int t = 0; t < 10; t++) begin
         int p1, p2;
         p1 = $urandom_range(3, 24);
         p2 = (t % 3 == 0) ? p1 : $urandom_range(3, 24);
         start_meas(p1, p2, $urandom_range(0, p1 - 1), $urandom_range(0, p2 - 1));
         finish_meas(t[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
